ex_dispatch_stage: RTL and testbench

- Parametrised register-read/dispatch stage between the integer scheduler and the ALU and branch units.
- Captures the issued micro-op with its physical-register operands and resolves BTB-hit qualification.
- Routes the micro-op into a per-channel FIFO (ALU, branch) with valid/ready handshakes. Downstream backpressure and flush are handled without losing or duplicating ops.
- Emits wakeups when an op actually leaves the stage, not when it is accepted.

---
 rtl/ex_dispatch_pkg.sv | 46 ++++
 rtl/ex_chan_fifo.sv | 61 ++++++
 rtl/ex_dispatch_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_ex_dispatch_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_dispatch_pkg.sv
// ex_dispatch_pkg: shared widths, ins_type bit positions and channel entry
// payloads for the register-read/dispatch stage.
package ex_dispatch_pkg;

  localparam int unsigned EX_XLEN  = 32;
  localparam int unsigned EX_PRF_W = 6;
  localparam int unsigned EX_ROB_W = 5;

  // ins_type one-hot bit positions; all-zero means conditional branch
  localparam int unsigned IT_ALU   = 0;
  localparam int unsigned IT_JAL   = 1;
  localparam int unsigned IT_JALR  = 2;
  localparam int unsigned IT_LUI   = 3;
  localparam int unsigned IT_AUIPC = 4;

  typedef struct packed {
    logic [EX_XLEN-1:0]  a;
    logic [EX_XLEN-1:0]  b;
    logic [3:0]          opc;
    logic [EX_ROB_W-1:0] rob;
    logic [EX_PRF_W-1:0] dest;
    logic                wk;
  } alu_entry_t;

  typedef struct packed {
    logic [EX_XLEN-1:0]  op1;
    logic [EX_XLEN-1:0]  op2;
    logic [EX_XLEN-1:0]  offset;
    logic [EX_XLEN-1:0]  pc;
    logic                auipc;
    logic                lui;
    logic                jal;
    logic                jalr;
    logic [2:0]          cond;
    logic [EX_ROB_W:0]   rob;
    logic [EX_PRF_W-1:0] dest;
    logic [1:0]          bm_pred;
    logic [1:0]          btype;
    logic                btb_vld;
    logic                btb_correct;
    logic                btb_way;
    logic [EX_XLEN-1:0]  target;
    logic                wk;
  } bnch_entry_t;

endpackage

// File: rtl/ex_chan_fifo.sv
// ex_chan_fifo: count-based channel FIFO, head entry drives the output.
// Ports: i_clk, i_rst (sync, active-high), i_flush (empties FIFO),
//        i_enq/i_enq_data (write, ignored when full or flushing),
//        i_deq (pop when valid), o_head, o_valid (count!=0), o_full.
module ex_chan_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_enq,
  input  logic [W-1:0] i_enq_data,
  input  logic         i_deq,
  output logic [W-1:0] o_head,
  output logic         o_valid,
  output logic         o_full
);
  import ex_dispatch_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_enq;
  logic             w_deq;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_head  = r_mem[r_rptr];

  // Full blocks enqueue even when the head leaves this cycle.
  assign w_enq = i_enq & ~o_full & ~i_flush;
  assign w_deq = i_deq & o_valid;

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_enq) r_mem[r_wptr] <= i_enq_data;
  end

endmodule

// File: rtl/ex_dispatch_stage.sv
// ex_dispatch_stage: register-read/dispatch between the integer scheduler and
// the ALU / branch units. Qualifies BTB hits, routes each accepted op into
// one channel FIFO and pulses a wakeup when a waking op leaves its channel.
// Ports: issue_* (scheduler side), rs*_o/rs*_data_i (PRF read), alu_* and
//        bnch_* (channel outputs with valid/ready), *_wakeup_* (pulses).
// Build option: EX_DISPATCH_BYPASS_EN adds wb_* ports and forwards writeback
//        data over PRF read data at accept.
module ex_dispatch_stage
  import ex_dispatch_pkg::*;
#(
  parameter int unsigned XLEN     = EX_XLEN,
  parameter int unsigned PRF_W    = EX_PRF_W,
  parameter int unsigned ROB_W    = EX_ROB_W,
  parameter int unsigned CH_DEPTH = 2
`ifdef EX_DISPATCH_BYPASS_EN
  ,
  parameter int unsigned N_WB     = 2
`endif
) (
  input  logic              cpu_clock_i,
  input  logic              cpu_reset_i,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [ROB_W:0]    issue_rob_i,
  input  logic [PRF_W-1:0]  issue_rs1_i,
  input  logic [PRF_W-1:0]  issue_rs2_i,
  output logic [PRF_W-1:0]  rs1_o,
  output logic [PRF_W-1:0]  rs2_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [3:0]        opcode_i,
  input  logic [4:0]        ins_type_i,
  input  logic              imm_sel_i,
  input  logic [XLEN-1:0]   immediate_i,
  input  logic [PRF_W-1:0]  dest_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [1:0]        bm_pred_i,
  input  logic [1:0]        btype_i,
  input  logic              btb_vld_i,
  input  logic              btb_correct_i,
  input  logic              btb_way_i,
  input  logic              btb_idx_i,
  input  logic [XLEN-1:0]   btb_target_i,
  output logic              alu_valid_o,
  input  logic              alu_ready_i,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  output logic [3:0]        alu_opc_o,
  output logic [ROB_W-1:0]  alu_rob_o,
  output logic [PRF_W-1:0]  alu_dest_o,
  output logic              bnch_valid_o,
  input  logic              bnch_ready_i,
  output logic [XLEN-1:0]   bnch_op1_o,
  output logic [XLEN-1:0]   bnch_op2_o,
  output logic [XLEN-1:0]   bnch_offset_o,
  output logic [XLEN-1:0]   bnch_pc_o,
  output logic              bnch_auipc_o,
  output logic              bnch_lui_o,
  output logic              bnch_jal_o,
  output logic              bnch_jalr_o,
  output logic [2:0]        bnch_cond_o,
  output logic [ROB_W:0]    bnch_rob_o,
  output logic [PRF_W-1:0]  bnch_dest_o,
  output logic [1:0]        bnch_bm_pred_o,
  output logic [1:0]        bnch_btype_o,
  output logic              bnch_btb_vld_o,
  output logic              bnch_btb_correct_o,
  output logic              bnch_btb_way_o,
  output logic [XLEN-1:0]   bnch_btb_target_o,
  output logic              alu_wakeup_valid_o,
  output logic              bnch_wakeup_valid_o,
  output logic [PRF_W-1:0]  alu_wakeup_dest_o,
  output logic [PRF_W-1:0]  bnch_wakeup_dest_o
`ifdef EX_DISPATCH_BYPASS_EN
  ,
  input  logic [N_WB-1:0]       wb_valid_i,
  input  logic [N_WB*PRF_W-1:0] wb_dest_i,
  input  logic [N_WB*XLEN-1:0]  wb_data_i
`endif
);

  logic        w_slot;
  logic [XLEN-1:0] w_eff_pc;
  logic        w_hit;
  logic        w_btb_ok;
  logic        w_to_alu;
  logic        w_to_bnch;
  logic        w_wk;
  logic        w_acc;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  alu_entry_t  w_alu_in;
  bnch_entry_t w_bnch_in;
  alu_entry_t  w_alu_head;
  bnch_entry_t w_bnch_head;
  logic        w_alu_valid;
  logic        w_bnch_valid;
  logic        w_alu_full;
  logic        w_bnch_full;
  logic        w_alu_deq;
  logic        w_bnch_deq;
  logic        r_alu_wk_vld;
  logic        r_bnch_wk_vld;
  logic [PRF_W-1:0] r_alu_wk_dest;
  logic [PRF_W-1:0] r_bnch_wk_dest;

  assign rs1_o = issue_rs1_i;
  assign rs2_o = issue_rs2_i;

  // Slot within the fetch pair: an upper-half PC forces slot 1.
  assign w_slot   = pc_i[2] ? 1'b1 : issue_rob_i[0];
  assign w_eff_pc = {pc_i[XLEN-1:3], w_slot, pc_i[1:0]};
  assign w_hit    = btb_vld_i & (btb_idx_i == w_slot);
  assign w_btb_ok = w_hit & btb_correct_i;

  // A BTB-confirmed ALU op is redirected to the branch unit and never wakes.
  // Branch routing is the complement so exactly one FIFO takes each op.
  assign w_to_alu  = ins_type_i[IT_ALU] & ~w_btb_ok;
  assign w_to_bnch = ~w_to_alu;
  assign w_wk      = (|ins_type_i) & ~w_btb_ok;

  // Ready depends only on registered occupancy, never on downstream ready.
  assign issue_ready_o = ~w_alu_full & ~w_bnch_full;
  assign w_acc         = issue_valid_i & issue_ready_o & ~flush_i;

`ifdef EX_DISPATCH_BYPASS_EN
  // Lowest-numbered matching writeback port wins; x0 is never forwarded.
  always_comb begin
    w_rs1_val = rs1_data_i;
    w_rs2_val = rs2_data_i;
    for (int k = int'(N_WB) - 1; k >= 0; k--) begin
      if (wb_valid_i[k] && (wb_dest_i[k*PRF_W +: PRF_W] == issue_rs1_i) &&
          (issue_rs1_i != '0))
        w_rs1_val = wb_data_i[k*XLEN +: XLEN];
      if (wb_valid_i[k] && (wb_dest_i[k*PRF_W +: PRF_W] == issue_rs2_i) &&
          (issue_rs2_i != '0))
        w_rs2_val = wb_data_i[k*XLEN +: XLEN];
    end
  end
`else
  assign w_rs1_val = rs1_data_i;
  assign w_rs2_val = rs2_data_i;
`endif

  // Channel entry payloads.
  always_comb begin
    w_alu_in      = '0;
    w_alu_in.a    = w_rs1_val;
    w_alu_in.b    = imm_sel_i ? immediate_i : w_rs2_val;
    w_alu_in.opc  = opcode_i;
    w_alu_in.rob  = issue_rob_i[ROB_W-1:0];
    w_alu_in.dest = dest_i;
    w_alu_in.wk   = w_wk;

    w_bnch_in             = '0;
    w_bnch_in.op1         = w_rs1_val;
    w_bnch_in.op2         = w_rs2_val;
    w_bnch_in.offset      = immediate_i;
    w_bnch_in.pc          = w_eff_pc;
    w_bnch_in.auipc       = ins_type_i[IT_AUIPC];
    w_bnch_in.lui         = ins_type_i[IT_LUI];
    w_bnch_in.jal         = ins_type_i[IT_JAL];
    w_bnch_in.jalr        = ins_type_i[IT_JALR];
    w_bnch_in.cond        = opcode_i[2:0];
    w_bnch_in.rob         = issue_rob_i;
    w_bnch_in.dest        = dest_i;
    w_bnch_in.bm_pred     = bm_pred_i;
    w_bnch_in.btype       = btype_i;
    w_bnch_in.btb_vld     = w_hit;
    w_bnch_in.btb_correct = w_btb_ok;
    w_bnch_in.btb_way     = btb_way_i;
    w_bnch_in.target      = btb_target_i;
    w_bnch_in.wk          = w_wk;
  end

  ex_chan_fifo #(.W($bits(alu_entry_t)), .DEPTH(CH_DEPTH)) u_alu_fifo (
    .i_clk      (cpu_clock_i),
    .i_rst      (cpu_reset_i),
    .i_flush    (flush_i),
    .i_enq      (w_acc & w_to_alu),
    .i_enq_data (w_alu_in),
    .i_deq      (alu_ready_i),
    .o_head     (w_alu_head),
    .o_valid    (w_alu_valid),
    .o_full     (w_alu_full)
  );

  ex_chan_fifo #(.W($bits(bnch_entry_t)), .DEPTH(CH_DEPTH)) u_bnch_fifo (
    .i_clk      (cpu_clock_i),
    .i_rst      (cpu_reset_i),
    .i_flush    (flush_i),
    .i_enq      (w_acc & w_to_bnch),
    .i_enq_data (w_bnch_in),
    .i_deq      (bnch_ready_i),
    .o_head     (w_bnch_head),
    .o_valid    (w_bnch_valid),
    .o_full     (w_bnch_full)
  );

  assign w_alu_deq  = w_alu_valid & alu_ready_i;
  assign w_bnch_deq = w_bnch_valid & bnch_ready_i;

  // Wakeup pulses track departures; a departure under flush stays silent.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i || flush_i) begin
      r_alu_wk_vld   <= 1'b0;
      r_bnch_wk_vld  <= 1'b0;
      r_alu_wk_dest  <= '0;
      r_bnch_wk_dest <= '0;
    end else begin
      r_alu_wk_vld   <= w_alu_deq & w_alu_head.wk;
      r_bnch_wk_vld  <= w_bnch_deq & w_bnch_head.wk;
      r_alu_wk_dest  <= w_alu_head.dest;
      r_bnch_wk_dest <= w_bnch_head.dest;
    end
  end

  assign alu_wakeup_valid_o  = r_alu_wk_vld;
  assign bnch_wakeup_valid_o = r_bnch_wk_vld;
  assign alu_wakeup_dest_o   = r_alu_wk_dest;
  assign bnch_wakeup_dest_o  = r_bnch_wk_dest;

  assign alu_valid_o = w_alu_valid;
  assign alu_a_o     = w_alu_head.a;
  assign alu_b_o     = w_alu_head.b;
  assign alu_opc_o   = w_alu_head.opc;
  assign alu_rob_o   = w_alu_head.rob;
  assign alu_dest_o  = w_alu_head.dest;

  assign bnch_valid_o       = w_bnch_valid;
  assign bnch_op1_o         = w_bnch_head.op1;
  assign bnch_op2_o         = w_bnch_head.op2;
  assign bnch_offset_o      = w_bnch_head.offset;
  assign bnch_pc_o          = w_bnch_head.pc;
  assign bnch_auipc_o       = w_bnch_head.auipc;
  assign bnch_lui_o         = w_bnch_head.lui;
  assign bnch_jal_o         = w_bnch_head.jal;
  assign bnch_jalr_o        = w_bnch_head.jalr;
  assign bnch_cond_o        = w_bnch_head.cond;
  assign bnch_rob_o         = w_bnch_head.rob;
  assign bnch_dest_o        = w_bnch_head.dest;
  assign bnch_bm_pred_o     = w_bnch_head.bm_pred;
  assign bnch_btype_o       = w_bnch_head.btype;
  assign bnch_btb_vld_o     = w_bnch_head.btb_vld;
  assign bnch_btb_correct_o = w_bnch_head.btb_correct;
  assign bnch_btb_way_o     = w_bnch_head.btb_way;
  assign bnch_btb_target_o  = w_bnch_head.target;

endmodule

// File: tb/tb_ex_dispatch_stage.sv
// tb_ex_dispatch_stage: routing vector table, backpressure and flush
// sequences, and a randomized run against a queue-based reference model.
module tb_ex_dispatch_stage;

  localparam int unsigned D = 2;

  logic        cpu_clock_i, cpu_reset_i, flush_i;
  logic        issue_valid_i, issue_ready_o;
  logic [5:0]  issue_rob_i;
  logic [5:0]  issue_rs1_i, issue_rs2_i, rs1_o, rs2_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [3:0]  opcode_i;
  logic [4:0]  ins_type_i;
  logic        imm_sel_i;
  logic [31:0] immediate_i, pc_i, btb_target_i;
  logic [5:0]  dest_i;
  logic [1:0]  bm_pred_i, btype_i;
  logic        btb_vld_i, btb_correct_i, btb_way_i, btb_idx_i;
  logic        alu_valid_o, alu_ready_i;
  logic [31:0] alu_a_o, alu_b_o;
  logic [3:0]  alu_opc_o;
  logic [4:0]  alu_rob_o;
  logic [5:0]  alu_dest_o;
  logic        bnch_valid_o, bnch_ready_i;
  logic [31:0] bnch_op1_o, bnch_op2_o, bnch_offset_o, bnch_pc_o, bnch_btb_target_o;
  logic        bnch_auipc_o, bnch_lui_o, bnch_jal_o, bnch_jalr_o;
  logic [2:0]  bnch_cond_o;
  logic [5:0]  bnch_rob_o, bnch_dest_o;
  logic [1:0]  bnch_bm_pred_o, bnch_btype_o;
  logic        bnch_btb_vld_o, bnch_btb_correct_o, bnch_btb_way_o;
  logic        alu_wakeup_valid_o, bnch_wakeup_valid_o;
  logic [5:0]  alu_wakeup_dest_o, bnch_wakeup_dest_o;
`ifdef EX_DISPATCH_BYPASS_EN
  logic [1:0]  wb_valid_i;
  logic [11:0] wb_dest_i;
  logic [63:0] wb_data_i;
`endif

  ex_dispatch_stage dut (
    .cpu_clock_i(cpu_clock_i), .cpu_reset_i(cpu_reset_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rob_i(issue_rob_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .opcode_i(opcode_i), .ins_type_i(ins_type_i), .imm_sel_i(imm_sel_i),
    .immediate_i(immediate_i), .dest_i(dest_i), .pc_i(pc_i),
    .bm_pred_i(bm_pred_i), .btype_i(btype_i), .btb_vld_i(btb_vld_i),
    .btb_correct_i(btb_correct_i), .btb_way_i(btb_way_i), .btb_idx_i(btb_idx_i),
    .btb_target_i(btb_target_i),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_a_o(alu_a_o),
    .alu_b_o(alu_b_o), .alu_opc_o(alu_opc_o), .alu_rob_o(alu_rob_o), .alu_dest_o(alu_dest_o),
    .bnch_valid_o(bnch_valid_o), .bnch_ready_i(bnch_ready_i),
    .bnch_op1_o(bnch_op1_o), .bnch_op2_o(bnch_op2_o), .bnch_offset_o(bnch_offset_o),
    .bnch_pc_o(bnch_pc_o), .bnch_auipc_o(bnch_auipc_o), .bnch_lui_o(bnch_lui_o),
    .bnch_jal_o(bnch_jal_o), .bnch_jalr_o(bnch_jalr_o), .bnch_cond_o(bnch_cond_o),
    .bnch_rob_o(bnch_rob_o), .bnch_dest_o(bnch_dest_o), .bnch_bm_pred_o(bnch_bm_pred_o),
    .bnch_btype_o(bnch_btype_o), .bnch_btb_vld_o(bnch_btb_vld_o),
    .bnch_btb_correct_o(bnch_btb_correct_o), .bnch_btb_way_o(bnch_btb_way_o),
    .bnch_btb_target_o(bnch_btb_target_o),
    .alu_wakeup_valid_o(alu_wakeup_valid_o), .bnch_wakeup_valid_o(bnch_wakeup_valid_o),
    .alu_wakeup_dest_o(alu_wakeup_dest_o), .bnch_wakeup_dest_o(bnch_wakeup_dest_o)
`ifdef EX_DISPATCH_BYPASS_EN
    , .wb_valid_i(wb_valid_i), .wb_dest_i(wb_dest_i), .wb_data_i(wb_data_i)
`endif
  );

  initial cpu_clock_i = 1'b0;
  always #5 cpu_clock_i = ~cpu_clock_i;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clock_i);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] a, b; logic [3:0] opc; logic [4:0] rob; logic [5:0] dest; logic wk;
  } m_alu_t;
  typedef struct packed {
    logic [31:0] op1, op2, offset, pc;
    logic auipc, lui, jal, jalr; logic [2:0] cond; logic [5:0] rob, dest;
    logic [1:0] bm_pred, btype; logic bvld, bcor, bway; logic [31:0] target; logic wk;
  } m_bnch_t;

  m_alu_t  alu_q[$];
  m_bnch_t bnch_q[$];
  logic       e_awk, e_bwk;
  logic [5:0] e_awd, e_bwd;

  // Derive the expected entry from the current issue inputs.
  task automatic model_accept();
    logic slot, hit, ok, is_alu, wk;
    logic [31:0] epc;
    m_alu_t  ae;
    m_bnch_t be;
    slot   = (pc_i[2] == 1'b1) ? 1'b1 : issue_rob_i[0];
    epc    = (pc_i & 32'hFFFF_FFFB) | (slot ? 32'd4 : 32'd0);
    hit    = btb_vld_i && (btb_idx_i == slot);
    ok     = hit && btb_correct_i;
    is_alu = (ins_type_i == 5'b00001) && !ok;
    wk     = (ins_type_i != 5'b00000) && !ok;
    if (is_alu) begin
      ae = '{a: rs1_data_i, b: (imm_sel_i ? immediate_i : rs2_data_i), opc: opcode_i,
             rob: issue_rob_i[4:0], dest: dest_i, wk: wk};
      alu_q.push_back(ae);
    end else begin
      be = '{op1: rs1_data_i, op2: rs2_data_i, offset: immediate_i, pc: epc,
             auipc: ins_type_i[4], lui: ins_type_i[3], jal: ins_type_i[1], jalr: ins_type_i[2],
             cond: opcode_i[2:0], rob: issue_rob_i, dest: dest_i, bm_pred: bm_pred_i,
             btype: btype_i, bvld: hit, bcor: ok, bway: btb_way_i, target: btb_target_i, wk: wk};
      bnch_q.push_back(be);
    end
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_step();
    logic rdy;
    m_alu_t  ah;
    m_bnch_t bh;
    rdy = (alu_q.size() < D) && (bnch_q.size() < D);
    e_awk = 1'b0;
    e_bwk = 1'b0;
    if (alu_ready_i && alu_q.size() > 0) begin
      ah = alu_q.pop_front();
      if (!flush_i && ah.wk) begin e_awk = 1'b1; e_awd = ah.dest; end
    end
    if (bnch_ready_i && bnch_q.size() > 0) begin
      bh = bnch_q.pop_front();
      if (!flush_i && bh.wk) begin e_bwk = 1'b1; e_bwd = bh.dest; end
    end
    if (flush_i) begin
      alu_q.delete();
      bnch_q.delete();
    end else if (issue_valid_i && rdy) begin
      model_accept();
    end
  endtask

  task automatic model_check();
    m_alu_t  ah;
    m_bnch_t bh;
    chk("rnd_ready", 256'(issue_ready_o), 256'((alu_q.size() < D) && (bnch_q.size() < D)));
    chk("rnd_rs_addr", 256'({rs1_o, rs2_o}), 256'({issue_rs1_i, issue_rs2_i}));
    chk("rnd_alu_valid", 256'(alu_valid_o), 256'(alu_q.size() > 0));
    if (alu_q.size() > 0) begin
      ah = alu_q[0];
      chk("rnd_alu_head", 256'({alu_a_o, alu_b_o, alu_opc_o, alu_rob_o, alu_dest_o}),
          256'({ah.a, ah.b, ah.opc, ah.rob, ah.dest}));
    end
    chk("rnd_bnch_valid", 256'(bnch_valid_o), 256'(bnch_q.size() > 0));
    if (bnch_q.size() > 0) begin
      bh = bnch_q[0];
      chk("rnd_bnch_head",
          256'({bnch_op1_o, bnch_op2_o, bnch_offset_o, bnch_pc_o, bnch_auipc_o, bnch_lui_o,
                bnch_jal_o, bnch_jalr_o, bnch_cond_o, bnch_rob_o, bnch_dest_o, bnch_bm_pred_o,
                bnch_btype_o, bnch_btb_vld_o, bnch_btb_correct_o, bnch_btb_way_o,
                bnch_btb_target_o}),
          256'(bh[186:1]));
    end
    chk("rnd_alu_wk", 256'(alu_wakeup_valid_o), 256'(e_awk));
    if (e_awk) chk("rnd_alu_wkd", 256'(alu_wakeup_dest_o), 256'(e_awd));
    chk("rnd_bnch_wk", 256'(bnch_wakeup_valid_o), 256'(e_bwk));
    if (e_bwk) chk("rnd_bnch_wkd", 256'(bnch_wakeup_dest_o), 256'(e_bwd));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  t; logic [31:0] pc; logic [5:0] rob;
    logic bv, bidx, bcor, sel; logic [31:0] r1, r2, imm;
    logic ea, eb, ew; logic [31:0] epc, ea_a, ea_b; logic ebcor;
  } vec_t;
  vec_t vecs[11];

  task automatic clear_inputs();
    flush_i = 0; issue_valid_i = 0; issue_rob_i = 0; issue_rs1_i = 0; issue_rs2_i = 0;
    rs1_data_i = 0; rs2_data_i = 0; opcode_i = 0; ins_type_i = 0; imm_sel_i = 0;
    immediate_i = 0; dest_i = 0; pc_i = 0; bm_pred_i = 0; btype_i = 0; btb_vld_i = 0;
    btb_correct_i = 0; btb_way_i = 0; btb_idx_i = 0; btb_target_i = 0;
    alu_ready_i = 0; bnch_ready_i = 0;
`ifdef EX_DISPATCH_BYPASS_EN
    wb_valid_i = 0; wb_dest_i = 0; wb_data_i = 0;
`endif
  endtask

  task automatic do_reset();
    cpu_reset_i = 1;
    repeat (2) tick();
    cpu_reset_i = 0;
    alu_q.delete();
    bnch_q.delete();
    e_awk = 0; e_bwk = 0; e_awd = 0; e_bwd = 0;
  endtask

  task automatic alu_op(input logic [5:0] d, input logic [31:0] a);
    ins_type_i = 5'b00001; btb_vld_i = 0; imm_sel_i = 0; pc_i = 32'h100;
    issue_rob_i = 6'(d); rs1_data_i = a; rs2_data_i = 32'h1; dest_i = d;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    chk("rst_alu_valid", 256'(alu_valid_o), 256'(0));
    chk("rst_bnch_valid", 256'(bnch_valid_o), 256'(0));
    chk("rst_wakeups", 256'({alu_wakeup_valid_o, bnch_wakeup_valid_o}), 256'(0));
    chk("rst_ready", 256'(issue_ready_o), 256'(1));

    //       t         pc           rob   bv bi bc sel r1     r2     imm    ea eb ew epc          a      b      bcor
    vecs[0]  = '{5'b00001, 32'h1000, 6'h02, 0, 0, 0, 1, 32'h5,  32'h9,  32'h10, 1, 0, 1, 32'h0,    32'h5,  32'h10, 0};
    vecs[1]  = '{5'b00010, 32'h1000, 6'h01, 0, 0, 0, 0, 32'h3,  32'h4,  32'h20, 0, 1, 1, 32'h1004, 32'h0,  32'h0,  0};
    vecs[2]  = '{5'b00001, 32'h2000, 6'h00, 1, 0, 1, 0, 32'h1,  32'h2,  32'h3,  0, 1, 0, 32'h2000, 32'h0,  32'h0,  1};
    vecs[3]  = '{5'b00001, 32'h2000, 6'h00, 1, 1, 1, 0, 32'h11, 32'h77, 32'h5,  1, 0, 1, 32'h0,    32'h11, 32'h77, 0};
    vecs[4]  = '{5'b00001, 32'h2004, 6'h00, 1, 1, 0, 1, 32'hA0, 32'hB0, 32'h44, 1, 0, 1, 32'h0,    32'hA0, 32'h44, 0};
    vecs[5]  = '{5'b00000, 32'h3004, 6'h00, 0, 0, 0, 0, 32'h1,  32'h2,  32'h8,  0, 1, 0, 32'h3004, 32'h0,  32'h0,  0};
    vecs[6]  = '{5'b00100, 32'h3000, 6'h03, 0, 0, 0, 0, 32'h1,  32'h2,  32'h8,  0, 1, 1, 32'h3004, 32'h0,  32'h0,  0};
    vecs[7]  = '{5'b01000, 32'h4008, 6'h02, 0, 0, 0, 0, 32'h1,  32'h2,  32'h8,  0, 1, 1, 32'h4008, 32'h0,  32'h0,  0};
    vecs[8]  = '{5'b10000, 32'h400C, 6'h00, 0, 0, 0, 0, 32'h1,  32'h2,  32'h8,  0, 1, 1, 32'h400C, 32'h0,  32'h0,  0};
    vecs[9]  = '{5'b00010, 32'h1000, 6'h01, 1, 1, 1, 0, 32'h1,  32'h2,  32'h8,  0, 1, 0, 32'h1004, 32'h0,  32'h0,  1};
    vecs[10] = '{5'b00000, 32'h5000, 6'h01, 1, 1, 0, 0, 32'h1,  32'h2,  32'h8,  0, 1, 0, 32'h5004, 32'h0,  32'h0,  0};

    for (int i = 0; i < 11; i++) begin
      ins_type_i = vecs[i].t; pc_i = vecs[i].pc; issue_rob_i = vecs[i].rob;
      btb_vld_i = vecs[i].bv; btb_idx_i = vecs[i].bidx; btb_correct_i = vecs[i].bcor;
      imm_sel_i = vecs[i].sel; rs1_data_i = vecs[i].r1; rs2_data_i = vecs[i].r2;
      immediate_i = vecs[i].imm; dest_i = 6'(10 + i);
      issue_valid_i = 1; alu_ready_i = 0; bnch_ready_i = 0;
      #1 chk($sformatf("vec%0d_ready", i), 256'(issue_ready_o), 256'(1));
      tick();
      issue_valid_i = 0;
      chk($sformatf("vec%0d_alu_valid", i), 256'(alu_valid_o), 256'(vecs[i].ea));
      chk($sformatf("vec%0d_bnch_valid", i), 256'(bnch_valid_o), 256'(vecs[i].eb));
      if (vecs[i].ea)
        chk($sformatf("vec%0d_alu_ab", i), 256'({alu_a_o, alu_b_o}), 256'({vecs[i].ea_a, vecs[i].ea_b}));
      if (vecs[i].eb)
        chk($sformatf("vec%0d_bnch_pc_bcor", i), 256'({bnch_pc_o, bnch_btb_correct_o}),
            256'({vecs[i].epc, vecs[i].ebcor}));
      alu_ready_i = 1; bnch_ready_i = 1;
      tick();
      chk($sformatf("vec%0d_wk", i), 256'({alu_wakeup_valid_o, bnch_wakeup_valid_o}),
          256'({vecs[i].ea & vecs[i].ew, vecs[i].eb & vecs[i].ew}));
      if (vecs[i].ew)
        chk($sformatf("vec%0d_wkd", i),
            256'(vecs[i].ea ? alu_wakeup_dest_o : bnch_wakeup_dest_o), 256'(10 + i));
      chk($sformatf("vec%0d_drained", i), 256'({alu_valid_o, bnch_valid_o}), 256'(0));
      alu_ready_i = 0; bnch_ready_i = 0;
      tick();
      chk($sformatf("vec%0d_wk_pulse", i), 256'({alu_wakeup_valid_o, bnch_wakeup_valid_o}), 256'(0));
    end

    // Backpressure: three ALU ops into a depth-2 channel, then drain in order.
    clear_inputs();
    do_reset();
    alu_op(6'd11, 32'h111); issue_valid_i = 1;
    tick();
    alu_op(6'd12, 32'h222);
    tick();
    chk("bp_full_ready", 256'(issue_ready_o), 256'(0));
    alu_op(6'd13, 32'h333);
    tick();
    chk("bp_head1", 256'({alu_valid_o, alu_dest_o, alu_a_o}), 256'({1'b1, 6'd11, 32'h111}));
    chk("bp_still_full", 256'(issue_ready_o), 256'(0));
    alu_ready_i = 1;
    tick();
    chk("bp_head2", 256'({alu_dest_o, alu_a_o}), 256'({6'd12, 32'h222}));
    chk("bp_wk1", 256'({alu_wakeup_valid_o, alu_wakeup_dest_o}), 256'({1'b1, 6'd11}));
    chk("bp_ready_again", 256'(issue_ready_o), 256'(1));
    tick();
    issue_valid_i = 0;
    chk("bp_head3", 256'({alu_valid_o, alu_dest_o, alu_a_o}), 256'({1'b1, 6'd13, 32'h333}));
    chk("bp_wk2", 256'({alu_wakeup_valid_o, alu_wakeup_dest_o}), 256'({1'b1, 6'd12}));
    tick();
    chk("bp_empty", 256'(alu_valid_o), 256'(0));
    chk("bp_wk3", 256'({alu_wakeup_valid_o, alu_wakeup_dest_o}), 256'({1'b1, 6'd13}));
    tick();
    chk("bp_wk_done", 256'(alu_wakeup_valid_o), 256'(0));

    // Flush with two queued ops, a coincident dequeue and a new issue.
    alu_op(6'd21, 32'h21); issue_valid_i = 1; alu_ready_i = 0;
    tick();
    ins_type_i = 5'b00010; dest_i = 6'd22;
    tick();
    chk("fl_pre", 256'({alu_valid_o, bnch_valid_o}), 256'({1'b1, 1'b1}));
    flush_i = 1; alu_ready_i = 1; alu_op(6'd23, 32'h23);
    tick();
    flush_i = 0; issue_valid_i = 0;
    chk("fl_valids", 256'({alu_valid_o, bnch_valid_o}), 256'(0));
    chk("fl_no_wk", 256'({alu_wakeup_valid_o, bnch_wakeup_valid_o}), 256'(0));
    chk("fl_ready", 256'(issue_ready_o), 256'(1));
    tick();
    chk("fl_dropped", 256'({alu_valid_o, bnch_valid_o, alu_wakeup_valid_o}), 256'(0));

`ifdef EX_DISPATCH_BYPASS_EN
    // Forwarding: lowest matching port wins; x0 always reads PRF data.
    clear_inputs();
    alu_op(6'd5, 32'h55); issue_rs1_i = 6'd7; issue_valid_i = 1;
    wb_valid_i = 2'b11; wb_dest_i = {6'd7, 6'd7}; wb_data_i = {32'hB, 32'hA};
    tick();
    issue_valid_i = 0; wb_valid_i = 0;
    chk("byp_lowest", 256'(alu_a_o), 256'(32'hA));
    alu_ready_i = 1;
    tick();
    alu_ready_i = 0; alu_op(6'd6, 32'h66); issue_rs1_i = 6'd0; issue_valid_i = 1;
    wb_valid_i = 2'b11; wb_dest_i = 12'd0; wb_data_i = {32'hB, 32'hA};
    tick();
    issue_valid_i = 0; wb_valid_i = 0;
    chk("byp_x0", 256'(alu_a_o), 256'(32'h66));
    clear_inputs();
`endif

    // Randomized run against the reference model.
    clear_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 7));
      case (r)
        0:       ins_type_i = 5'b00000;
        1, 6, 7: ins_type_i = 5'b00001;
        2:       ins_type_i = 5'b00010;
        3:       ins_type_i = 5'b00100;
        4:       ins_type_i = 5'b01000;
        default: ins_type_i = 5'b10000;
      endcase
      issue_valid_i = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      alu_ready_i   = ($urandom_range(0, 9) < 6);
      bnch_ready_i  = ($urandom_range(0, 9) < 6);
      issue_rob_i   = 6'($urandom); issue_rs1_i = 6'($urandom); issue_rs2_i = 6'($urandom);
      rs1_data_i    = $urandom; rs2_data_i = $urandom; opcode_i = 4'($urandom);
      imm_sel_i     = 1'($urandom); immediate_i = $urandom; dest_i = 6'($urandom);
      pc_i          = $urandom; bm_pred_i = 2'($urandom); btype_i = 2'($urandom);
      btb_vld_i     = 1'($urandom); btb_correct_i = 1'($urandom);
      btb_way_i     = 1'($urandom); btb_idx_i = 1'($urandom); btb_target_i = $urandom;
      #1;
      model_check();
      @(posedge cpu_clock_i);
      model_step();
      #1;
    end

    // Reset with both channels occupied; reset wins over a concurrent flush.
    clear_inputs();
    alu_op(6'd30, 32'h30); issue_valid_i = 1;
    tick();
    ins_type_i = 5'b00100;
    tick();
    issue_valid_i = 0; flush_i = 1; alu_ready_i = 1; cpu_reset_i = 1;
    tick();
    cpu_reset_i = 0; flush_i = 0; alu_ready_i = 0;
    chk("rst2_state", 256'({alu_valid_o, bnch_valid_o, alu_wakeup_valid_o, bnch_wakeup_valid_o}), 256'(0));
    chk("rst2_ready", 256'(issue_ready_o), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
